// File: rtl/counter_seq_ctrl.sv
// Shares one external down-counter between two requesters: round-robin grant,
// load, optional halve, prescaled decrement to zero, per-requester done pulse.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitrates when one is present
//   LOAD  | grant pulse, counter latches the captured start value
//   HALVE | counter divides its contents by two
//   RUN   | prescaled decrement until the counter reports zero
//   DONE  | done pulse to the job owner, round-robin pointer updated
module counter_seq_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] load0,
  input  logic             half0,
  input  logic             req1,
  input  logic [WIDTH-1:0] load1,
  input  logic             half1,
  input  logic             abort,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic             cnt_latch,
  output logic [WIDTH-1:0] cnt_in,
  output logic             cnt_dec,
  output logic             cnt_halve,
  input  logic             cnt_zero
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HALVE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic   [PW-1:0]  presc;
  logic   [WIDTH-1:0] remain;
  logic             owner;
  logic             job_half;
  logic             last_grant;

  logic             pick_valid;
  logic             pick;
  logic [WIDTH-1:0] pick_load;
  logic             pick_half;
  logic [PW-1:0]    presc_step;
  logic             entry_dec;
  logic             run_dec;

  // Tie goes to the requester that was not served last.
  always_comb begin
    pick_valid = req0 | req1;
    pick       = 1'b0;
    if (req0 && req1) begin
      pick = ~last_grant;
    end else begin
      pick = req1;
    end
    pick_load = pick ? load1 : load0;
    pick_half = pick ? half1 : half0;
  end

  // Because cnt_dec is a flop, the decrement for a cycle is decided one cycle
  // early. remain shadows the counter value after every pending decrement so a
  // decrement is never scheduled into a cycle where the counter already reads
  // zero; cnt_zero itself still decides when the job ends.
  always_comb begin
    presc_step = (presc == PRE_LAST) ? '0 : presc + PW'(1);
    entry_dec  = (PRE_LAST == '0) && (remain != '0);
    run_dec    = (presc_step == PRE_LAST) && (remain != '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      presc      <= '0;
      remain     <= '0;
      owner      <= 1'b0;
      job_half   <= 1'b0;
      last_grant <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      busy       <= 1'b0;
      cnt_latch  <= 1'b0;
      cnt_in     <= '0;
      cnt_dec    <= 1'b0;
      cnt_halve  <= 1'b0;
    end else begin
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      cnt_latch <= 1'b0;
      cnt_dec   <= 1'b0;
      cnt_halve <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            state     <= S_LOAD;
            owner     <= pick;
            job_half  <= pick_half;
            remain    <= pick_load;
            gnt0      <= ~pick;
            gnt1      <= pick;
            cnt_latch <= 1'b1;
            cnt_in    <= pick_load;
            busy      <= 1'b1;
          end
        end

        S_LOAD: begin
          if (abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            last_grant <= owner;
          end else if (job_half) begin
            state     <= S_HALVE;
            cnt_halve <= 1'b1;
            remain    <= remain >> 1;
          end else begin
            state   <= S_RUN;
            presc   <= '0;
            cnt_dec <= entry_dec;
            if (entry_dec) begin
              remain <= remain - WIDTH'(1);
            end
          end
        end

        S_HALVE: begin
          if (abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            last_grant <= owner;
          end else begin
            state   <= S_RUN;
            presc   <= '0;
            cnt_dec <= entry_dec;
            if (entry_dec) begin
              remain <= remain - WIDTH'(1);
            end
          end
        end

        S_RUN: begin
          if (abort) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            last_grant <= owner;
          end else if (cnt_zero) begin
            state <= S_DONE;
            done0 <= ~owner;
            done1 <= owner;
          end else begin
            presc   <= presc_step;
            cnt_dec <= run_dec;
            if (run_dec) begin
              remain <= remain - WIDTH'(1);
            end
          end
        end

        S_DONE: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          last_grant <= owner;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Controller that shares one down-counter datapath (load / decrement / divide-by-two / zero flag) between two requesters.
- Round-robin arbitration: the winner's value is loaded, optionally halved, then decremented at a prescaled rate until the counter reports zero, and a per-requester done pulse is returned.
- Sits between the requester logic and the counter instance. It owns every control input of the counter.

Parameters:
- WIDTH, 4, width of the load value and of the counter `in` bus.
- PRESCALE, 1, clock cycles per decrement step in RUN. Legal range ≥ 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- req0  input  1  requester 0 request. Level; held until gnt0.
- load0  input  WIDTH  requester 0 start value, sampled when granted.
- half0  input  1  requester 0: halve the value after load.
- req1  input  1  requester 1 request.
- load1  input  WIDTH  requester 1 start value.
- half1  input  1  requester 1 halve select.
- abort  input  1  synchronous abort of the current job.
- gnt0  output  1  one-cycle grant to requester 0.
- gnt1  output  1  one-cycle grant to requester 1.
- done0  output  1  one-cycle completion pulse, requester 0.
- done1  output  1  one-cycle completion pulse, requester 1.
- busy  output  1  high in any state other than IDLE.
- cnt_latch  output  1  to counter latch.
- cnt_in  output  WIDTH  to counter in.
- cnt_dec  output  1  to counter dec.
- cnt_halve  output  1  to counter divide-by-two.
- cnt_zero  input  1  from counter zero. Valid the cycle after any counter update.

Behaviour:
- All outputs are registered.
- Reset (async, reset_n=0) forces:
  - state=IDLE;
  - all outputs 0, cnt_in=0;
  - prescaler=0;
  - last_grant=1, so requester 0 wins the first tie.
- Reset asserted mid-job discards the job with no done pulse. Counter contents are left untouched.

States and transitions:
- IDLE:
  - If only one req is high, select it.
  - If both are high, select the requester not equal to last_grant.
  - On selection, capture load/half into job registers → LOAD.
- LOAD (1 cycle):
  - gnt_x=1, cnt_latch=1, cnt_in=captured value.
  - Next state: HALVE if half is set, else RUN.
- HALVE (1 cycle): cnt_halve=1 → RUN.
- RUN:
  - Prescaler starts at 0 on entry.
  - Each cycle, if cnt_zero=1 → DONE; no dec is issued that cycle.
  - Otherwise, when the prescaler reaches PRESCALE-1, issue cnt_dec=1 for one cycle and clear the prescaler. Otherwise increment the prescaler.
- DONE (1 cycle): done_x=1 for the job owner; last_grant←owner → IDLE.

Abort:
- abort=1 in LOAD, HALVE or RUN → IDLE next cycle.
- No done pulse; last_grant←owner; no further counter control is issued.
- abort in IDLE or DONE is ignored.
- If abort and cnt_zero are both high in RUN, abort wins: no done pulse.

Invariants:
- cnt_dec is never asserted while cnt_zero=1 (no underflow).
- cnt_latch, cnt_dec and cnt_halve are mutually exclusive.

Timing (value L, no halve):
- gnt at cycle n.
- RUN spans L·PRESCALE+1 cycles.
- done at cycle n+L·PRESCALE+2.
- Exactly L cnt_dec pulses.
- L=0: RUN lasts 1 cycle, zero dec pulses, done at n+2.
- With halve: add 1 cycle; dec count is floor(L/2).

Back-to-back jobs:
- A req still high when DONE→IDLE is arbitrated again in IDLE. Minimum gap between grants = job length + 1 cycle.
- Requests arriving while busy wait in IDLE. No queueing beyond the level req.

Prescaler:
- Width max(1, clog2(PRESCALE)).
- Wraps only through the compare with PRESCALE-1.

Test Plan:
- Reset, then req0=1, load0=5, half0=0, PRESCALE=1 → gnt0 at n with cnt_in=5 and cnt_latch; 5 cnt_dec pulses; done0 at n+7; busy low at n+8.
- req0 and req1 raised together and held, load0=3, load1=2:
  - gnt0 first, done0;
  - then gnt1 next (round-robin), done1;
  - then gnt0 again; grants strictly alternate.
- req1=1, load1=9, half1=1 → cnt_latch, then cnt_halve next cycle, then exactly 4 cnt_dec pulses, then done1.
- PRESCALE=3, load0=2 → cnt_dec pulses 3 cycles apart (2 total); done0 at n+8.
- load0=0 → no cnt_dec; done0 at n+2.
- Abort cases:
  - abort during RUN after 2 decs of load 6 → busy low next cycle; no done0; no further cnt_dec.
  - reset_n pulsed low mid-RUN → all outputs 0 immediately (async); next simultaneous request is granted to req0.
